// File: rtl/dmem_pkg.sv
// Shared types, default parameters and helpers for the data memory family.
package dmem_pkg;

  localparam int unsigned DEF_DATA_W         = 8;
  localparam int unsigned DEF_ADDR_W         = 8;
  localparam int unsigned DEF_LATENCY        = 5;
  localparam bit          DEF_CLEAR_ON_RESET = 1'b1;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = 1; x < v; x = x << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_memory_param_if.sv
// Request/response bus between the load/store path and the data memory.
interface data_memory_param_if import dmem_pkg::*; #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              busywait;
  logic              error;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait, error
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait, error
  );

endinterface

// File: rtl/dmem_latency_ctr.sv
// Access latency counter: load a start value, count down to zero, flag zero.
module dmem_latency_ctr #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned LOAD_VAL = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero_c
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(LOAD_VAL);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/data_memory_param.sv
// Parametrised single-port data memory with clocked access latency,
// post-reset clear sweep and illegal-request (read+write) detection.
module data_memory_param import dmem_pkg::*; #(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned LATENCY        = DEF_LATENCY,
  parameter bit          CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
  input  logic               clock,
  input  logic               reset,
  data_memory_param_if.slave bus
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned CNT_W    = clog2(LATENCY) + 1;
  localparam int unsigned LOAD_VAL = LATENCY - 1;
  localparam state_t      RST_ST   = CLEAR_ON_RESET ? INIT : IDLE;

  state_t            state;
  state_t            state_next;

  logic              req_c;
  logic              both_c;
  logic              clr_last_c;
  logic              cnt_zero_c;

  logic              busywait_c;
  logic              error_c;
  logic              accept_c;
  logic              commit_c;
  logic              clear_we_c;
  logic              cnt_dec_c;

  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] readdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req_c      = bus.read ^ bus.write;
  assign both_c     = bus.read & bus.write;
  assign clr_last_c = (clr_ptr == '1);

  // State register; reset lands in the sweep or directly in IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RST_ST;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (clr_last_c) state_next = IDLE;
      IDLE:    if (req_c)      state_next = BUSY;
      BUSY:    if (cnt_zero_c) state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = RST_ST;
    endcase
  end

  // Per-state controls and the combinational handshake outputs.
  always_comb begin
    busywait_c = 1'b0;
    error_c    = 1'b0;
    accept_c   = 1'b0;
    commit_c   = 1'b0;
    clear_we_c = 1'b0;
    cnt_dec_c  = 1'b0;
    case (state)
      INIT: begin
        busywait_c = 1'b1;
        clear_we_c = 1'b1;
      end
      IDLE: begin
        busywait_c = req_c;
        error_c    = both_c;
        accept_c   = req_c;
      end
      BUSY: begin
        busywait_c = 1'b1;
        cnt_dec_c  = 1'b1;
        commit_c   = cnt_zero_c;
      end
      default: ;
    endcase
  end

  assign bus.busywait = busywait_c;
  assign bus.error    = error_c;

  dmem_latency_ctr #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (LOAD_VAL)
  ) u_lat (
    .clock  (clock),
    .reset  (reset),
    .load   (accept_c),
    .dec    (cnt_dec_c),
    .zero_c (cnt_zero_c)
  );

  // Capture the request so bus changes during BUSY cannot affect the access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q   <= OP_READ;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept_c) begin
      op_q   <= bus.write ? OP_WRITE : OP_READ;
      addr_q <= bus.address;
      data_q <= bus.writedata;
    end
  end

  // Clear sweep pointer; stops at the last word, no wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clr_ptr <= '0;
    end else if (clear_we_c && !clr_last_c) begin
      clr_ptr <= clr_ptr + ADDR_W'(1);
    end
  end

  // Storage array: sweep writes zeros, otherwise a committed store writes data.
  always_ff @(posedge clock) begin
    if (clear_we_c) begin
      mem[clr_ptr] <= '0;
    end else if (commit_c && (op_q == OP_WRITE)) begin
      mem[addr_q] <= data_q;
    end
  end

  // Load result register, updated only on a committed read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readdata_q <= '0;
    end else if (commit_c && (op_q == OP_READ)) begin
      readdata_q <= mem[addr_q];
    end
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_data_memory_param.sv
// Directed bench for data_memory_param: default config plus a wide, single-latency config.
module tb_data_memory_param;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  data_memory_param_if #(.DATA_W(8),  .ADDR_W(8))  bus_a ();
  data_memory_param_if #(.DATA_W(32), .ADDR_W(10)) bus_b ();

  data_memory_param #(
    .DATA_W(8), .ADDR_W(8), .LATENCY(5), .CLEAR_ON_RESET(1'b1)
  ) u_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  data_memory_param #(
    .DATA_W(32), .ADDR_W(10), .LATENCY(1), .CLEAR_ON_RESET(1'b1)
  ) u_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One access on bus_a; optionally changes address/data on the second busy cycle.
  task automatic access_a(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic chg, input logic [7:0] addr2,
                          output int busy, output logic [7:0] rdata, output logic tmo);
    @(negedge clock);
    bus_a.read      = !wr;
    bus_a.write     = wr;
    bus_a.address   = addr;
    bus_a.writedata = wdata;
    busy = 0;
    tmo  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (!bus_a.busywait) begin
        tmo = 1'b0;
        break;
      end
      busy++;
      if (i == 1 && chg) begin
        bus_a.address   = addr2;
        bus_a.writedata = ~wdata;
      end
      @(negedge clock);
    end
    rdata = bus_a.readdata;
    bus_a.read  = 1'b0;
    bus_a.write = 1'b0;
  endtask

  task automatic access_b(input logic wr, input logic [9:0] addr, input logic [31:0] wdata,
                          output int busy, output logic [31:0] rdata, output logic tmo);
    @(negedge clock);
    bus_b.read      = !wr;
    bus_b.write     = wr;
    bus_b.address   = addr;
    bus_b.writedata = wdata;
    busy = 0;
    tmo  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (!bus_b.busywait) begin
        tmo = 1'b0;
        break;
      end
      busy++;
      @(negedge clock);
    end
    rdata = bus_b.readdata;
    bus_b.read  = 1'b0;
    bus_b.write = 1'b0;
  endtask

  initial begin
    int          busy;
    int          cnt_a;
    int          cnt_b;
    logic        tmo;
    logic [7:0]  rd8;
    logic [31:0] rd32;

    bus_a.read = 1'b0; bus_a.write = 1'b0; bus_a.address = '0; bus_a.writedata = '0;
    bus_b.read = 1'b0; bus_b.write = 1'b0; bus_b.address = '0; bus_b.writedata = '0;

    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_busywait_a", bus_a.busywait, 1);
    check("rst_readdata_a", bus_a.readdata, 0);
    check("rst_error_a",    bus_a.error,    0);

    // Release reset and measure the clear sweep length of both instances.
    @(negedge clock);
    reset = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 1100; i++) begin
      #1;
      if (bus_a.busywait) cnt_a++;
      if (bus_b.busywait) cnt_b++;
      @(negedge clock);
    end
    check("sweep_cycles_a", cnt_a, 256);
    check("sweep_cycles_b", cnt_b, 1024);

    // Write then read back at LATENCY=5.
    access_a(1'b1, 8'h12, 8'hA5, 1'b0, 8'h00, busy, rd8, tmo);
    check("wr12_timeout", tmo, 0);
    check("wr12_busy",    busy, 6);
    access_a(1'b0, 8'h12, 8'h00, 1'b0, 8'h00, busy, rd8, tmo);
    check("rd12_busy",    busy, 6);
    check("rd12_data",    rd8, 8'hA5);

    // Address change during BUSY must not redirect the read.
    access_a(1'b1, 8'h34, 8'h3C, 1'b0, 8'h00, busy, rd8, tmo);
    check("wr34_busy",    busy, 6);
    access_a(1'b0, 8'h12, 8'h00, 1'b1, 8'h34, busy, rd8, tmo);
    check("rd_midaddr",   rd8, 8'hA5);
    access_a(1'b0, 8'h34, 8'h00, 1'b0, 8'h00, busy, rd8, tmo);
    check("rd34_data",    rd8, 8'h3C);

    // Read and write together in IDLE: error, no stall, no access.
    @(negedge clock);
    bus_a.read = 1'b1; bus_a.write = 1'b1;
    bus_a.address = 8'h12; bus_a.writedata = 8'hFF;
    #1;
    check("both_error",    bus_a.error,    1);
    check("both_busywait", bus_a.busywait, 0);
    repeat (3) @(negedge clock);
    #1;
    check("both_error_held", bus_a.error,    1);
    check("both_readdata",   bus_a.readdata, 8'h3C);
    bus_a.read = 1'b0; bus_a.write = 1'b0;
    #1;
    check("both_error_clear", bus_a.error, 0);
    access_a(1'b0, 8'h12, 8'h00, 1'b0, 8'h00, busy, rd8, tmo);
    check("both_mem_kept", rd8, 8'hA5);

    // Reset mid-write at cnt=2: abandoned, readdata cleared, sweep follows.
    @(negedge clock);
    bus_a.write = 1'b1; bus_a.address = 8'h50; bus_a.writedata = 8'h99;
    repeat (3) @(negedge clock);
    #1;
    check("midwr_busy", bus_a.busywait, 1);
    reset = 1'b0;
    #1;
    check("midwr_rst_readdata", bus_a.readdata, 0);
    check("midwr_rst_busywait", bus_a.busywait, 1);
    bus_a.write = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 1100; i++) begin
      #1;
      if (bus_a.busywait) cnt_a++;
      @(negedge clock);
    end
    check("sweep2_cycles_a", cnt_a, 256);
    access_a(1'b0, 8'h50, 8'h00, 1'b0, 8'h00, busy, rd8, tmo);
    check("midwr_not_written", rd8, 8'h00);
    access_a(1'b0, 8'h12, 8'h00, 1'b0, 8'h00, busy, rd8, tmo);
    check("sweep_clear_12", rd8, 8'h00);
    access_a(1'b0, 8'h34, 8'h00, 1'b0, 8'h00, busy, rd8, tmo);
    check("sweep_clear_34", rd8, 8'h00);

    // Wide config, LATENCY=1: two stall cycles per access.
    access_b(1'b1, 10'h3FF, 32'hDEADBEEF, busy, rd32, tmo);
    check("b_wr_timeout", tmo, 0);
    check("b_wr_busy",    busy, 2);
    access_b(1'b1, 10'h000, 32'h12345678, busy, rd32, tmo);
    check("b_wr0_busy",   busy, 2);
    access_b(1'b0, 10'h3FF, 32'h0, busy, rd32, tmo);
    check("b_rd_busy",    busy, 2);
    check("b_rd_3ff",     rd32, 32'hDEADBEEF);
    access_b(1'b0, 10'h000, 32'h0, busy, rd32, tmo);
    check("b_rd_000",     rd32, 32'h12345678);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
